// File: rtl/block_chk_pkg.sv
// Shared definitions for the block nesting checker: keyword token type,
// error codes, the word separator and a letter-case folding helper.
package block_chk_pkg;

    typedef enum logic [2:0] {
        TOK_NONE,
        TOK_BEGIN,
        TOK_CASE,
        TOK_END,
        TOK_ENDCASE
    } tok_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_EMPTY = 2'd1;
    localparam logic [1:0] ERR_TYPE  = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    localparam logic [7:0] SPACE = 8'h20;

    // Map A-Z onto a-z; every other code passes through untouched.
    function automatic logic [7:0] fold_char(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A)
            return c | 8'h20;
        else
            return c;
    endfunction

endpackage

// File: rtl/block_nest_checker_type_stack.sv
// type_stack: 1-bit-wide LIFO recording the type of each open block
// (0 = begin, 1 = case).
// Ports:
//   clk, reset     clock and synchronous active-high reset (empties the stack)
//   push, pop, din push din / pop top; push on full and pop on empty are ignored
//   top            type of the top entry (0 when empty)
//   count          number of stored entries
//   empty, full    count == 0 / count == DEPTH
module type_stack #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             din,
    output logic             top,
    output logic [PTR_W-1:0] count,
    output logic             empty,
    output logic             full
);

    // Sized to the full pointer range so count can index it directly;
    // entries at or above DEPTH are never written.
    logic mem [0:(2**PTR_W)-1];

    assign empty = (count == '0);
    assign full  = (count == PTR_W'(DEPTH));
    assign top   = empty ? 1'b0 : mem[count - PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + PTR_W'(1);
        end else if (pop && !empty) begin
            count <= count - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !full)
            mem[count] <= din;
    end

endmodule

// File: rtl/block_nest_checker.sv
// block_nest_checker: consumes a stream of ASCII characters, splits it into
// space-separated words and checks that begin/end and case/endcase blocks
// nest properly with matching types.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   in          ASCII character, consumed when in_valid is 1
//   in_valid    character qualifier
//   word_done   one-cycle pulse after a non-empty word is committed
//   depth       current number of open blocks
//   result      1 iff depth == 0 and no error has been seen
//   err         sticky error flag
//   err_code    first error: 0 none, 1 close on empty, 2 type mismatch, 3 overflow
module block_nest_checker
    import block_chk_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 5,
    parameter int CASE_SENS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic             word_done,
    output logic [PTR_W-1:0] depth,
    output logic             result,
    output logic             err,
    output logic [1:0]       err_code
);

    // Last seven characters of the current word, newest in the low byte.
    logic [55:0]      buf_q;
    // Word length, saturating at 8 so that long words never classify.
    logic [3:0]       len_q;

    logic [7:0]       ch;
    logic             is_space;
    logic             commit;
    tok_t             tok;

    logic             push_req, pop_req, push_eff, pop_eff;
    logic             push_din, stk_top, stk_empty, stk_full;
    logic [PTR_W-1:0] stk_count, depth_nx;
    logic             new_err;
    logic [1:0]       new_code;

    assign ch       = (CASE_SENS != 0) ? in : fold_char(in);
    assign is_space = (in == SPACE);
    assign commit   = in_valid && is_space && (len_q != 4'd0);

    // Keyword classifier on the low len_q bytes of the buffer.
    always_comb begin
        tok = TOK_NONE;
        case (len_q)
            4'd3: if (buf_q[23:0] == "end")     tok = TOK_END;
            4'd4: if (buf_q[31:0] == "case")    tok = TOK_CASE;
            4'd5: if (buf_q[39:0] == "begin")   tok = TOK_BEGIN;
            4'd7: if (buf_q[55:0] == "endcase") tok = TOK_ENDCASE;
            default: tok = TOK_NONE;
        endcase
    end

    // Stack requests and error detection for the word being committed.
    always_comb begin
        push_req = commit && (tok == TOK_BEGIN || tok == TOK_CASE);
        pop_req  = commit && (tok == TOK_END || tok == TOK_ENDCASE);
        push_din = (tok == TOK_CASE);
        push_eff = push_req && !stk_full;
        pop_eff  = pop_req && !stk_empty;

        new_err  = 1'b0;
        new_code = ERR_NONE;
        if (push_req && stk_full) begin
            new_err  = 1'b1;
            new_code = ERR_OVF;
        end else if (pop_req && stk_empty) begin
            new_err  = 1'b1;
            new_code = ERR_EMPTY;
        end else if (pop_req && (stk_top != (tok == TOK_ENDCASE))) begin
            // Mismatched close still pops the entry.
            new_err  = 1'b1;
            new_code = ERR_TYPE;
        end

        if (push_eff)
            depth_nx = stk_count + PTR_W'(1);
        else if (pop_eff)
            depth_nx = stk_count - PTR_W'(1);
        else
            depth_nx = stk_count;
    end

    type_stack #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_eff),
        .pop   (pop_eff),
        .din   (push_din),
        .top   (stk_top),
        .count (stk_count),
        .empty (stk_empty),
        .full  (stk_full)
    );

    assign depth = stk_count;

    // Control state: word length, pulse, sticky error and result.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= 4'd0;
            word_done <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            result    <= 1'b1;
        end else begin
            word_done <= commit;
            if (in_valid) begin
                if (is_space)
                    len_q <= 4'd0;
                else if (len_q != 4'd8)
                    len_q <= len_q + 4'd1;
            end
            if (new_err && !err) begin
                err      <= 1'b1;
                err_code <= new_code;
            end
            result <= (depth_nx == '0) && !(err || new_err);
        end
    end

    // Character data: only the length counter matters after reset.
    always_ff @(posedge clk) begin
        if (in_valid && !is_space)
            buf_q <= {buf_q[47:0], ch};
    end

endmodule

// File: tb/tb_block_nest_checker.sv
module tb_block_nest_checker;

    typedef struct packed {
        logic       wd;
        logic [4:0] dep;
        logic       res;
        logic       er;
        logic [1:0] ec;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic [7:0] din = 8'h00;

    logic       wd  [3];
    logic [4:0] dp  [3];
    logic       res [3];
    logic       er  [3];
    logic [1:0] ec  [3];

    int checks = 0;
    int errors = 0;

    // Three configurations see the same stream:
    // 0: DEPTH 16 case-insensitive, 1: DEPTH 16 lowercase only, 2: DEPTH 2.
    block_nest_checker #(.DEPTH(16), .PTR_W(5), .CASE_SENS(0)) u0 (
        .clk(clk), .reset(rst), .in(din), .in_valid(vld),
        .word_done(wd[0]), .depth(dp[0]), .result(res[0]), .err(er[0]), .err_code(ec[0]));
    block_nest_checker #(.DEPTH(16), .PTR_W(5), .CASE_SENS(1)) u1 (
        .clk(clk), .reset(rst), .in(din), .in_valid(vld),
        .word_done(wd[1]), .depth(dp[1]), .result(res[1]), .err(er[1]), .err_code(ec[1]));
    block_nest_checker #(.DEPTH(2), .PTR_W(5), .CASE_SENS(0)) u2 (
        .clk(clk), .reset(rst), .in(din), .in_valid(vld),
        .word_done(wd[2]), .depth(dp[2]), .result(res[2]), .err(er[2]), .err_code(ec[2]));

    always #5 clk = ~clk;

    // Reference model: words as strings, open blocks as a queue of types.
    int    dmax [3] = '{16, 16, 2};
    bit    csen [3] = '{0, 1, 0};
    string w    [3];
    int    stk  [3][$];
    bit    merr [3];
    int    mcode[3];

    exp3_t expq[$];

    function automatic void set_err(int k, int c);
        if (!merr[k]) begin
            merr[k]  = 1'b1;
            mcode[k] = c;
        end
    endfunction

    function automatic void do_pop(int k, int want);
        int t;
        if (stk[k].size() == 0) begin
            set_err(k, 1);
        end else begin
            t = stk[k].pop_back();
            if (t != want) set_err(k, 2);
        end
    endfunction

    function automatic void do_push(int k, int typ);
        if (stk[k].size() == dmax[k]) set_err(k, 3);
        else stk[k].push_back(typ);
    endfunction

    function automatic void model_step(bit r, bit v, byte c);
        exp3_t e;
        string s;
        bit    pulse;
        for (int k = 0; k < 3; k++) begin
            pulse = 1'b0;
            if (r) begin
                w[k] = "";
                stk[k].delete();
                merr[k]  = 1'b0;
                mcode[k] = 0;
            end else if (v) begin
                if (c != 8'h20) begin
                    w[k] = $sformatf("%s%c", w[k], c);
                end else if (w[k].len() != 0) begin
                    pulse = 1'b1;
                    s = csen[k] ? w[k] : w[k].tolower();
                    if (s == "begin")        do_push(k, 0);
                    else if (s == "case")    do_push(k, 1);
                    else if (s == "end")     do_pop(k, 0);
                    else if (s == "endcase") do_pop(k, 1);
                    w[k] = "";
                end
            end
            e[k].wd  = pulse;
            e[k].dep = 5'(stk[k].size());
            e[k].er  = merr[k];
            e[k].ec  = 2'(mcode[k]);
            e[k].res = (stk[k].size() == 0) && !merr[k];
        end
        expq.push_back(e);
    endfunction

    task automatic step(bit r, bit v, byte c);
        @(negedge clk);
        rst = r;
        vld = v;
        din = c;
        model_step(r, v, c);
    endtask

    // Send a string; gap_pct is the chance of an idle cycle before each char.
    task automatic send(string s, int gap_pct);
        for (int i = 0; i < s.len(); i++) begin
            while ($urandom_range(99) < gap_pct)
                step(1'b0, 1'b0, byte'($urandom_range(8'h20, 8'h7A)));
            step(1'b0, 1'b1, s[i]);
        end
    endtask

    function automatic void chk(string name, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[cfg%0d] at %0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endfunction

    // Monitor: one expectation per driven cycle, compared after the edge.
    always @(posedge clk) begin
        exp3_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk("word_done", k, int'(wd[k]),  int'(e[k].wd));
                chk("depth",     k, int'(dp[k]),  int'(e[k].dep));
                chk("result",    k, int'(res[k]), int'(e[k].res));
                chk("err",       k, int'(er[k]),  int'(e[k].er));
                chk("err_code",  k, int'(ec[k]),  int'(e[k].ec));
            end
        end
    end

    string words [12] = '{"begin", "case", "end", "endcase", "BEGIN", "End",
                          "EndCase", "foo", "end;", "begins", "x", "endcaseX"};

    initial begin
        step(1'b1, 1'b0, 8'h00);
        send("begin case endcase end ", 0);

        step(1'b1, 1'b0, 8'h00);
        send("BeGiN eNd ", 0);

        step(1'b1, 1'b0, 8'h00);
        send("begin endcase ", 0);
        send("case endcase ", 0);

        step(1'b1, 1'b0, 8'h00);
        send("end begin end ", 0);

        step(1'b1, 1'b0, 8'h00);
        send("begin begin begin ", 0);

        step(1'b1, 1'b0, 8'h00);
        send("begin", 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h20);
            step(1'b0, 1'b1, 8'h20);
        end
        send("en", 0);
        step(1'b1, 1'b1, "d");
        send(" d ", 0);
        send("longwordend begin ", 30);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(99) < 4) step(1'b1, 1'($urandom_range(1)), 8'h20);
            send(words[$urandom_range(11)], 20);
            repeat ($urandom_range(1, 2)) step(1'b0, 1'b1, 8'h20);
        end

        step(1'b0, 1'b0, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
